// File: rtl/medidor_faixa_uc_pkg.sv
// Shared types for the range-meter control unit: state codes and the bundle of
// control outputs, plus the Moore output decoder.
package medidor_faixa_uc_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MEDIR       = 4'h2,
        AGUARDA_MED = 4'h3,
        TRANSMITE   = 4'h4,
        ESPERA_TX   = 4'h5,
        PROX_CHAR   = 4'h6,
        FIM_FRAME   = 4'h7,
        INTERVALO   = 4'h8,
        ACERTO      = 4'h9,
        TIMEOUT     = 4'hA
    } estado_t;

    typedef struct packed {
        logic zera;
        logic zera_char;
        logic zera_time;
        logic mensurar;
        logic partida_tx;
        logic conta_prox_char;
        logic conta_time;
        logic pronto;
        logic fim_jogo;
        logic erro_timeout;
    } saidas_t;

    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            PREPARA: begin
                s.zera      = 1'b1;
                s.zera_char = 1'b1;
                s.zera_time = 1'b1;
            end
            MEDIR:     s.mensurar        = 1'b1;
            TRANSMITE: s.partida_tx      = 1'b1;
            PROX_CHAR: s.conta_prox_char = 1'b1;
            FIM_FRAME: begin
                s.zera_char = 1'b1;
                s.zera_time = 1'b1;
                s.pronto    = 1'b1;
            end
            INTERVALO: s.conta_time = 1'b1;
            ACERTO:    s.fim_jogo   = 1'b1;
            TIMEOUT: begin
                s.zera         = 1'b1;
                s.erro_timeout = 1'b1;
            end
            default:   s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/medidor_faixa_uc_if.sv
// Control/status bundle between the range-meter control unit (master) and its
// datapath (slave).
interface medidor_faixa_uc_if;
    logic       ligar;
    logic       pronto_medida;
    logic       pronto_tx;
    logic       is_ultimo_char;
    logic       fim_time;
    logic       acertou;
    logic       zera;
    logic       zera_char;
    logic       zera_time;
    logic       mensurar;
    logic       partida_tx;
    logic       conta_prox_char;
    logic       conta_time;
    logic       pronto;
    logic       fim_jogo;
    logic       erro_timeout;
    logic [3:0] db_estado;

    modport master (
        input  ligar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, acertou,
        output zera, zera_char, zera_time, mensurar, partida_tx, conta_prox_char,
               conta_time, pronto, fim_jogo, erro_timeout, db_estado
    );

    modport slave (
        output ligar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, acertou,
        input  zera, zera_char, zera_time, mensurar, partida_tx, conta_prox_char,
               conta_time, pronto, fim_jogo, erro_timeout, db_estado
    );
endinterface

// File: rtl/medidor_faixa_uc_contador_m.sv
// Modulo-M up counter with async and sync clear; fim is high while the count
// sits at its terminal value M-1.
module contador_m #(
    parameter int M = 1_500_000,
    parameter int N = 21
) (
    input  logic clock,
    input  logic zera_as,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (zera_s)
            q_d = '0;
        else if (conta)
            q_d = (q_q == N'(M - 1)) ? '0 : q_q + N'(1);
    end

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign fim = (q_q == N'(M - 1));

endmodule

// File: rtl/medidor_faixa_uc.sv
// Range-meter control unit: Moore FSM sequencing measurement, 4-char frame,
// interval wait and hit detection. MEDIDOR_UC_TIMEOUT_EN enables the watchdog.
module medidor_faixa_uc
    import medidor_faixa_uc_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1_500_000,
    parameter int N_TIMEOUT      = 21
) (
    input  logic               clock,
    input  logic               reset,
    medidor_faixa_uc_if.master bus
);

    estado_t estado_q, estado_d;
    saidas_t saidas_q, saidas_d;
    logic    fim_watchdog;

`ifdef MEDIDOR_UC_TIMEOUT_EN
    contador_m #(
        .M (TIMEOUT_CICLOS),
        .N (N_TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .zera_as (reset),
        .zera_s  (estado_q != AGUARDA_MED),
        .conta   (estado_q == AGUARDA_MED),
        .fim     (fim_watchdog)
    );
`else
    assign fim_watchdog = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:     if (bus.ligar) estado_d = PREPARA;
            PREPARA:     estado_d = MEDIR;
            MEDIR:       estado_d = AGUARDA_MED;
            AGUARDA_MED: begin
                if (bus.pronto_medida)  estado_d = TRANSMITE;
                else if (!bus.ligar)    estado_d = INICIAL;
                else if (fim_watchdog)  estado_d = TIMEOUT;
            end
            TRANSMITE:   estado_d = ESPERA_TX;
            // Frame is always completed once started; ligar is only looked at in FIM_FRAME.
            ESPERA_TX:   if (bus.pronto_tx) estado_d = bus.is_ultimo_char ? FIM_FRAME : PROX_CHAR;
            PROX_CHAR:   estado_d = TRANSMITE;
            FIM_FRAME:   estado_d = bus.ligar ? INTERVALO : INICIAL;
            INTERVALO: begin
                if (!bus.ligar)         estado_d = INICIAL;
                else if (bus.acertou)   estado_d = ACERTO;
                else if (bus.fim_time)  estado_d = MEDIR;
            end
            ACERTO:      if (!bus.ligar) estado_d = INICIAL;
            TIMEOUT:     estado_d = MEDIR;
            default:     estado_d = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state and registered with it, so they
    // track the state register exactly without a combinational output path.
    always_comb begin
        saidas_d = decodifica(estado_d);
`ifndef MEDIDOR_UC_TIMEOUT_EN
        saidas_d.erro_timeout = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            saidas_q <= saidas_d;
        end
    end

    assign bus.zera            = saidas_q.zera;
    assign bus.zera_char       = saidas_q.zera_char;
    assign bus.zera_time       = saidas_q.zera_time;
    assign bus.mensurar        = saidas_q.mensurar;
    assign bus.partida_tx      = saidas_q.partida_tx;
    assign bus.conta_prox_char = saidas_q.conta_prox_char;
    assign bus.conta_time      = saidas_q.conta_time;
    assign bus.pronto          = saidas_q.pronto;
    assign bus.fim_jogo        = saidas_q.fim_jogo;
    assign bus.erro_timeout    = saidas_q.erro_timeout;
    assign bus.db_estado       = estado_q;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Self-checking bench for medidor_faixa_uc: transition table through a
// scoreboard queue, then multi-cycle frame/reset/hit/watchdog sequences.
module tb_medidor_faixa_uc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    medidor_faixa_uc_if bus ();

    medidor_faixa_uc #(
        .TIMEOUT_CICLOS (50),
        .N_TIMEOUT      (6)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // input bits {ligar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, acertou}
    localparam logic [5:0] L = 6'b100000, PM = 6'b010000, PT = 6'b001000,
                           UL = 6'b000100, FT = 6'b000010, AC = 6'b000001;
    // output bits {zera, zera_char, zera_time, mensurar, partida_tx, conta_prox_char,
    //              conta_time, pronto, fim_jogo, erro_timeout}
    localparam logic [9:0] ZR = 10'h200, ZC = 10'h100, ZT = 10'h080, MS = 10'h040,
                           PX = 10'h020, CP = 10'h010, CT = 10'h008, PR = 10'h004,
                           FJ = 10'h002, ER = 10'h001, NO = 10'h000;

    typedef struct packed {
        logic [5:0] in;
        logic [3:0] est;
        logic [9:0] outs;
    } vec_t;

    typedef struct {
        logic [3:0] est;
        logic [9:0] outs;
        int         idx;
    } exp_t;

    localparam int NV = 42;
    vec_t tab [NV];
    exp_t sb [$];

    int nvec = 0;
    int nerr = 0;

    int  cnt_med, cnt_tx, sel;
    int  n_part, n_prox, n_pronto;
    bit  seen, bad;

    function automatic logic [9:0] outs_now();
        return {bus.zera, bus.zera_char, bus.zera_time, bus.mensurar, bus.partida_tx,
                bus.conta_prox_char, bus.conta_time, bus.pronto, bus.fim_jogo,
                bus.erro_timeout};
    endfunction

    task automatic check(input string nome, input logic [3:0] est, input logic [9:0] outs);
        nvec++;
        if (bus.db_estado !== est || outs_now() !== outs) begin
            nerr++;
            $display("FAIL %s: estado=%h saidas=%b, esperado estado=%h saidas=%b",
                     nome, bus.db_estado, outs_now(), est, outs);
        end
    endtask

    task automatic check_int(input string nome, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: obtido=%0d esperado=%0d", nome, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {bus.ligar, bus.pronto_medida, bus.pronto_tx, bus.is_ultimo_char,
         bus.fim_time, bus.acertou} = in;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Datapath model: pronto_medida 10 cycles after mensurar, pronto_tx 20 cycles
    // after partida_tx, char counter driven by conta_prox_char/zera_char.
    task automatic dp_cycle();
        bus.pronto_medida  = (cnt_med == 1);
        bus.pronto_tx      = (cnt_tx == 1);
        bus.is_ultimo_char = (sel == 3);
        if (cnt_med > 0) cnt_med--;
        if (cnt_tx > 0) cnt_tx--;
        tick();
        if (bus.mensurar) cnt_med = 10;
        if (bus.partida_tx) cnt_tx = 20;
        if (bus.conta_prox_char) sel++;
        if (bus.zera_char) sel = 0;
    endtask

    task automatic dp_reset();
        cnt_med = 0; cnt_tx = 0; sel = 0;
        n_part = 0; n_prox = 0; n_pronto = 0;
    endtask

    initial begin
        tab[0]  = '{6'b0,       4'h0, NO};
        tab[1]  = '{L,          4'h1, ZR | ZC | ZT};
        tab[2]  = '{L,          4'h2, MS};
        tab[3]  = '{L,          4'h3, NO};
        tab[4]  = '{L,          4'h3, NO};
        tab[5]  = '{L | PM,     4'h4, PX};
        tab[6]  = '{L,          4'h5, NO};
        tab[7]  = '{6'b0,       4'h5, NO};
        tab[8]  = '{L | PT,     4'h6, CP};
        tab[9]  = '{L,          4'h4, PX};
        tab[10] = '{L,          4'h5, NO};
        tab[11] = '{L | PT | UL, 4'h7, ZC | ZT | PR};
        tab[12] = '{L,          4'h8, CT};
        tab[13] = '{L | FT,     4'h2, MS};
        tab[14] = '{L,          4'h3, NO};
        tab[15] = '{PM,         4'h4, PX};
        tab[16] = '{6'b0,       4'h5, NO};
        tab[17] = '{PT | UL,    4'h7, ZC | ZT | PR};
        tab[18] = '{6'b0,       4'h0, NO};
        tab[19] = '{L,          4'h1, ZR | ZC | ZT};
        tab[20] = '{L,          4'h2, MS};
        tab[21] = '{L,          4'h3, NO};
        tab[22] = '{6'b0,       4'h0, NO};
        tab[23] = '{L,          4'h1, ZR | ZC | ZT};
        tab[24] = '{L,          4'h2, MS};
        tab[25] = '{L | PM,     4'h3, NO};
        tab[26] = '{L,          4'h3, NO};
        tab[27] = '{L | PM,     4'h4, PX};
        tab[28] = '{L | PT | UL, 4'h5, NO};
        tab[29] = '{L | PT | UL, 4'h7, ZC | ZT | PR};
        tab[30] = '{L,          4'h8, CT};
        tab[31] = '{AC | FT,    4'h0, NO};
        tab[32] = '{L,          4'h1, ZR | ZC | ZT};
        tab[33] = '{L,          4'h2, MS};
        tab[34] = '{L,          4'h3, NO};
        tab[35] = '{L | PM,     4'h4, PX};
        tab[36] = '{L,          4'h5, NO};
        tab[37] = '{L | PT | UL, 4'h7, ZC | ZT | PR};
        tab[38] = '{L | AC,     4'h8, CT};
        tab[39] = '{L | AC | FT, 4'h9, FJ};
        tab[40] = '{L | FT,     4'h9, FJ};
        tab[41] = '{6'b0,       4'h0, NO};

        rst = 1'b1;
        drive(6'b0);
        dp_reset();
        tick();
        tick();
        check("reset", 4'h0, NO);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            drive(tab[i].in);
            sb.push_back('{tab[i].est, tab[i].outs, i});
            tick();
            e = sb.pop_front();
            check($sformatf("vetor%0d", e.idx), e.est, e.outs);
        end

        // Reset in the middle of ESPERA_TX with ligar held high
        dp_reset();
        drive(L);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            dp_cycle();
            if (bus.db_estado == 4'h5) seen = 1'b1;
        end
        check_int("chega_espera_tx", int'(seen), 1);
        #2 rst = 1'b1;
        #1 check("reset_assincrono", 4'h0, NO);
        tick();
        check("reset_mantido", 4'h0, NO);
        drive(L);
        rst = 1'b0;
        tick();
        check("pos_reset_prepara", 4'h1, ZR | ZC | ZT);

        // Full frame with realistic datapath timing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dp_reset();
        drive(L);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            dp_cycle();
            if (bus.partida_tx) n_part++;
            if (bus.conta_prox_char) n_prox++;
            if (bus.pronto) begin
                n_pronto++;
                seen = 1'b1;
            end
        end
        check_int("frame_terminou", int'(seen), 1);
        check("frame_fim_frame", 4'h7, ZC | ZT | PR);
        check_int("frame_partidas", n_part, 4);
        check_int("frame_prox_char", n_prox, 3);
        check_int("frame_prontos", n_pronto, 1);
        dp_cycle();
        check("frame_intervalo", 4'h8, CT);

        // acertou and fim_time together in INTERVALO: acertou wins
        drive(L | AC | FT);
        tick();
        check("acerto_prioridade", 4'h9, FJ);
        drive(L);
        tick();
        check("acerto_mantido", 4'h9, FJ);
        drive(6'b0);
        tick();
        check("acerto_desliga", 4'h0, NO);

        // ligar dropped during the first char: frame still completes, then idle
        dp_reset();
        drive(L);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            dp_cycle();
            if (bus.db_estado == 4'h5) bus.ligar = 1'b0;
            if (bus.partida_tx) n_part++;
            if (bus.pronto) seen = 1'b1;
        end
        check_int("desliga_frame_terminou", int'(seen), 1);
        check_int("desliga_partidas", n_part, 4);
        dp_cycle();
        check("desliga_volta_inicial", 4'h0, NO);

        // Waiting for a measurement that never arrives
        drive(L);
        tick();
        tick();
        check("espera_medir", 4'h2, MS);
        tick();
        check("espera_aguarda", 4'h3, NO);
`ifdef MEDIDOR_UC_TIMEOUT_EN
        begin
            int n;
            n = 0;
            seen = 1'b0;
            for (int i = 1; i <= 60 && !seen; i++) begin
                tick();
                n = i;
                if (bus.erro_timeout) seen = 1'b1;
            end
            check_int("timeout_ciclos", n, 50);
            check("timeout_pulso", 4'hA, ZR | ER);
            tick();
            check("timeout_remede", 4'h2, MS);
            tick();
            check("timeout_aguarda", 4'h3, NO);
            bad = 1'b0;
            for (int i = 0; i < 49; i++) begin
                tick();
                if (bus.erro_timeout || bus.db_estado != 4'h3) bad = 1'b1;
            end
            check_int("timeout_sem_erro_49", int'(bad), 0);
            drive(L | PM);
            tick();
            drive(L);
            check("timeout_medida_ultimo_ciclo", 4'h4, PX);
        end
`else
        bad = 1'b0;
        for (int i = 0; i < 10_000; i++) begin
            tick();
            if (bus.erro_timeout !== 1'b0 || bus.db_estado !== 4'h3) bad = 1'b1;
        end
        check_int("sem_watchdog_espera", int'(bad), 0);
        check("sem_watchdog_final", 4'h3, NO);
`endif

        drive(6'b0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
